// File: rtl/scoreboard_reg_file_if.sv
// Register-file bus: read ports, two writeback ports,
// issue port and scoreboard status.
interface scoreboard_reg_file_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] ra1, ra2;
  logic [DATA_W-1:0] rd1, rd2;
  logic              busy1, busy2;
  logic              we_a, we_b;
  logic [ADDR_W-1:0] wa_a, wa_b;
  logic [DATA_W-1:0] wd_a, wd_b;
  logic              iss_v;
  logic [ADDR_W-1:0] iss_addr;
  logic              wr_conflict;
  logic [ADDR_W:0]   pend_cnt;

  modport master (
    output ra1, ra2, we_a, wa_a, wd_a,
    output we_b, wa_b, wd_b, iss_v, iss_addr,
    input  rd1, rd2, busy1, busy2,
    input  wr_conflict, pend_cnt
  );

  modport slave (
    input  ra1, ra2, we_a, wa_a, wd_a,
    input  we_b, wa_b, wd_b, iss_v, iss_addr,
    output rd1, rd2, busy1, busy2,
    output wr_conflict, pend_cnt
  );
endinterface

// File: rtl/scoreboard_reg_file.sv
// 2R/2W register file with forwarding and a
// per-register pending-write scoreboard.
module scoreboard_reg_file #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic clk,
  input logic rst_n,
  scoreboard_reg_file_if.slave bus
);

  localparam logic [ADDR_W:0] NR = (ADDR_W+1)'(NREGS);

  function automatic logic wr_ok(
    input logic [ADDR_W-1:0] a
  );
    return ({1'b0, a} < NR) &&
           !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic [DATA_W-1:0] rf [NREGS];
  logic [NREGS-1:0]  pend, pend_nxt;
  logic [ADDR_W:0]   cnt, cnt_nxt;
  logic              conf;
  logic              va, vb, vi;

  assign va = bus.we_a & wr_ok(bus.wa_a);
  assign vb = bus.we_b & wr_ok(bus.wa_b);
  assign vi = bus.iss_v & wr_ok(bus.iss_addr);

  // issue beats writeback so a new producer stays pending
  always_comb begin
    pend_nxt = pend;
    cnt_nxt  = '0;
    for (int r = 0; r < NREGS; r++) begin
      if (vi && bus.iss_addr == ADDR_W'(r))
        pend_nxt[r] = 1'b1;
      else if ((va && bus.wa_a == ADDR_W'(r)) ||
               (vb && bus.wa_b == ADDR_W'(r)))
        pend_nxt[r] = 1'b0;
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, pend_nxt[r]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++)
        rf[r] <= '0;
      pend <= '0;
      cnt  <= '0;
      conf <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (va && bus.wa_a == ADDR_W'(r))
          rf[r] <= bus.wd_a;
        if (vb && bus.wa_b == ADDR_W'(r))
          rf[r] <= bus.wd_b;
      end
      pend <= pend_nxt;
      cnt  <= cnt_nxt;
      conf <= va & vb & (bus.wa_a == bus.wa_b);
    end
  end

  logic [ADDR_W-1:0] ra  [2];
  logic [DATA_W-1:0] rd  [2];
  logic              bsy [2];
  logic              hit [2];

  assign ra[0] = bus.ra1;
  assign ra[1] = bus.ra2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd[p]  = '0;
      bsy[p] = 1'b0;
      hit[p] = 1'b0;
      if (wr_ok(ra[p])) begin
        hit[p] = (va && bus.wa_a == ra[p]) ||
                 (vb && bus.wa_b == ra[p]);
        rd[p]  = rf[ra[p]];
        if (BYPASS != 0) begin
          if (vb && bus.wa_b == ra[p])
            rd[p] = bus.wd_b;
          else if (va && bus.wa_a == ra[p])
            rd[p] = bus.wd_a;
        end
        bsy[p] = pend[ra[p]] &
                 ~((BYPASS != 0) & hit[p] &
                   ~(vi & (bus.iss_addr == ra[p])));
      end
    end
  end

  assign bus.rd1         = rd[0];
  assign bus.rd2         = rd[1];
  assign bus.busy1       = bsy[0];
  assign bus.busy2       = bsy[1];
  assign bus.pend_cnt    = cnt;
  assign bus.wr_conflict = conf;

endmodule

// File: tb/tb_scoreboard_reg_file.sv
// Bench for scoreboard_reg_file: vector table, corner
// sequences and random traffic against a reference model.
module tb_scoreboard_reg_file;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scoreboard_reg_file_if #(.ADDR_W(5), .DATA_W(32)) ifc ();
  scoreboard_reg_file_if #(.ADDR_W(5), .DATA_W(32)) nbi ();

  scoreboard_reg_file u_dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc.slave)
  );

  scoreboard_reg_file #(.BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .bus(nbi.slave)
  );

  assign nbi.ra1      = ifc.ra1;
  assign nbi.ra2      = ifc.ra2;
  assign nbi.we_a     = ifc.we_a;
  assign nbi.wa_a     = ifc.wa_a;
  assign nbi.wd_a     = ifc.wd_a;
  assign nbi.we_b     = ifc.we_b;
  assign nbi.wa_b     = ifc.wa_b;
  assign nbi.wd_b     = ifc.wd_b;
  assign nbi.iss_v    = ifc.iss_v;
  assign nbi.iss_addr = ifc.iss_addr;

  int checks = 0;
  int failures = 0;

  // reference model: plain arrays updated per spec rules
  logic [31:0] m_rf [32];
  bit          m_pend [32];
  bit          m_conf;
  logic [31:0] n_rf [32];
  bit          n_pend [32];
  bit          n_conf;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic bit wok(input logic [4:0] a);
    return a != 5'd0;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (!wok(a)) return 32'd0;
    if (ifc.we_b && ifc.wa_b == a) return ifc.wd_b;
    if (ifc.we_a && ifc.wa_a == a) return ifc.wd_a;
    return m_rf[a];
  endfunction

  function automatic bit exp_busy(input logic [4:0] a);
    bit wr, is;
    if (!wok(a)) return 1'b0;
    wr = (ifc.we_a && ifc.wa_a == a) || (ifc.we_b && ifc.wa_b == a);
    is = ifc.iss_v && ifc.iss_addr == a;
    return m_pend[a] && !(wr && !is);
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    for (int r = 0; r < 32; r++) n += int'(m_pend[r]);
    return n;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_rf[r] = '0;
      m_pend[r] = 1'b0;
    end
    m_conf = 1'b0;
  endtask

  task automatic tick();
    for (int r = 0; r < 32; r++) begin
      n_rf[r] = m_rf[r];
      n_pend[r] = m_pend[r];
    end
    if (ifc.we_a && wok(ifc.wa_a)) begin
      n_rf[ifc.wa_a] = ifc.wd_a;
      n_pend[ifc.wa_a] = 1'b0;
    end
    if (ifc.we_b && wok(ifc.wa_b)) begin
      n_rf[ifc.wa_b] = ifc.wd_b;
      n_pend[ifc.wa_b] = 1'b0;
    end
    if (ifc.iss_v && wok(ifc.iss_addr))
      n_pend[ifc.iss_addr] = 1'b1;
    n_conf = ifc.we_a && ifc.we_b && wok(ifc.wa_a) &&
             ifc.wa_a == ifc.wa_b;
    @(posedge clk);
    for (int r = 0; r < 32; r++) begin
      m_rf[r] = n_rf[r];
      m_pend[r] = n_pend[r];
    end
    m_conf = n_conf;
    #1;
  endtask

  task automatic idle();
    ifc.we_a = 1'b0; ifc.wa_a = '0; ifc.wd_a = '0;
    ifc.we_b = 1'b0; ifc.wa_b = '0; ifc.wd_b = '0;
    ifc.iss_v = 1'b0; ifc.iss_addr = '0;
  endtask

  task automatic model_chk(input string tag);
    chk({tag, "_rd1"}, ifc.rd1, exp_rd(ifc.ra1));
    chk({tag, "_rd2"}, ifc.rd2, exp_rd(ifc.ra2));
    chk({tag, "_busy1"}, 32'(ifc.busy1), 32'(exp_busy(ifc.ra1)));
    chk({tag, "_busy2"}, 32'(ifc.busy2), 32'(exp_busy(ifc.ra2)));
    chk({tag, "_cnt"}, 32'(ifc.pend_cnt), 32'(exp_cnt()));
    chk({tag, "_conf"}, 32'(ifc.wr_conflict), 32'(m_conf));
  endtask

  typedef struct {
    logic        we_a;
    logic [4:0]  wa_a;
    logic [31:0] wd_a;
    logic        we_b;
    logic [4:0]  wa_b;
    logic [31:0] wd_b;
    logic        iss_v;
    logic [4:0]  iss_addr;
    logic [4:0]  ra1;
    logic [31:0] e_rd1;
    logic        e_busy1;
    logic [5:0]  e_cnt;
    logic        e_conf;
  } vec_t;

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 32'h0,
                1'b0, 5'd0, 5'd7, 32'h11, 1'b0, 6'd0, 1'b0};
    tbl[1]  = '{1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB,
                1'b0, 5'd0, 5'd7, 32'h11, 1'b0, 6'd0, 1'b0};
    tbl[2]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                1'b0, 5'd0, 5'd3, 32'hB, 1'b0, 6'd0, 1'b1};
    tbl[3]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                1'b0, 5'd0, 5'd3, 32'hB, 1'b0, 6'd0, 1'b0};
    tbl[4]  = '{1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'h0,
                1'b1, 5'd0, 5'd0, 32'h0, 1'b0, 6'd0, 1'b0};
    tbl[5]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                1'b1, 5'd9, 5'd0, 32'h0, 1'b0, 6'd0, 1'b0};
    tbl[6]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                1'b0, 5'd0, 5'd9, 32'h0, 1'b1, 6'd1, 1'b0};
    tbl[7]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99,
                1'b1, 5'd9, 5'd9, 32'h99, 1'b1, 6'd1, 1'b0};
    tbl[8]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                1'b0, 5'd0, 5'd9, 32'h99, 1'b1, 6'd1, 1'b0};
    tbl[9]  = '{1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'h0,
                1'b0, 5'd0, 5'd9, 32'h55, 1'b0, 6'd1, 1'b0};
    tbl[10] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                1'b0, 5'd0, 5'd9, 32'h55, 1'b0, 6'd0, 1'b0};

    idle();
    ifc.ra1 = 5'd5;
    ifc.ra2 = 5'd6;
    model_reset();
    #3;
    chk("rst_rd1", ifc.rd1, 32'd0);
    chk("rst_cnt", 32'(ifc.pend_cnt), 32'd0);
    chk("rst_conf", 32'(ifc.wr_conflict), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // async reset between edges
    ifc.we_a = 1'b1; ifc.wa_a = 5'd5; ifc.wd_a = 32'hDEADBEEF;
    ifc.iss_v = 1'b1; ifc.iss_addr = 5'd6;
    tick();
    idle();
    #1;
    chk("pre_rst_rd1", ifc.rd1, 32'hDEADBEEF);
    chk("pre_rst_cnt", 32'(ifc.pend_cnt), 32'd1);
    chk("pre_rst_busy2", 32'(ifc.busy2), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_rd1", ifc.rd1, 32'd0);
    chk("arst_cnt", 32'(ifc.pend_cnt), 32'd0);
    chk("arst_busy2", 32'(ifc.busy2), 32'd0);
    model_reset();
    #1;
    rst_n = 1'b1;
    ifc.ra2 = 5'd0;

    for (int i = 0; i < 11; i++) begin
      ifc.we_a = tbl[i].we_a;
      ifc.wa_a = tbl[i].wa_a;
      ifc.wd_a = tbl[i].wd_a;
      ifc.we_b = tbl[i].we_b;
      ifc.wa_b = tbl[i].wa_b;
      ifc.wd_b = tbl[i].wd_b;
      ifc.iss_v = tbl[i].iss_v;
      ifc.iss_addr = tbl[i].iss_addr;
      ifc.ra1 = tbl[i].ra1;
      #1;
      chk($sformatf("v%0d_rd1", i), ifc.rd1, tbl[i].e_rd1);
      chk($sformatf("v%0d_busy1", i), 32'(ifc.busy1),
          32'(tbl[i].e_busy1));
      chk($sformatf("v%0d_cnt", i), 32'(ifc.pend_cnt),
          32'(tbl[i].e_cnt));
      chk($sformatf("v%0d_conf", i), 32'(ifc.wr_conflict),
          32'(tbl[i].e_conf));
      tick();
    end
    idle();

    // no-bypass instance sees new data one cycle later
    ifc.we_a = 1'b1; ifc.wa_a = 5'd7; ifc.wd_a = 32'h22;
    ifc.ra1 = 5'd7;
    #1;
    chk("byp_rd1", ifc.rd1, 32'h22);
    chk("nobyp_old", nbi.rd1, 32'h11);
    tick();
    idle();
    #1;
    chk("nobyp_new", nbi.rd1, 32'h22);
    ifc.iss_v = 1'b1; ifc.iss_addr = 5'd12;
    tick();
    idle();
    ifc.we_a = 1'b1; ifc.wa_a = 5'd12; ifc.wd_a = 32'h3;
    ifc.ra1 = 5'd12;
    #1;
    chk("wb_busy_byp", 32'(ifc.busy1), 32'd0);
    chk("wb_busy_nobyp", 32'(nbi.busy1), 32'd1);
    tick();
    idle();

    // fill every writable register, then drain
    for (int r = 1; r < 32; r++) begin
      ifc.iss_v = 1'b1;
      ifc.iss_addr = 5'(r);
      tick();
    end
    idle();
    #1;
    chk("fill_cnt", 32'(ifc.pend_cnt), 32'd31);
    model_chk("fill");
    for (int r = 1; r < 32; r += 2) begin
      ifc.we_a = 1'b1; ifc.wa_a = 5'(r); ifc.wd_a = 32'(r);
      ifc.we_b = (r < 31);
      ifc.wa_b = 5'(r + 1); ifc.wd_b = 32'(r + 1);
      tick();
    end
    idle();
    #1;
    chk("drain_cnt", 32'(ifc.pend_cnt), 32'd0);
    model_chk("drain");

    for (int i = 0; i < 400; i++) begin
      ifc.we_a = 1'($urandom_range(0, 1));
      ifc.wa_a = 5'($urandom_range(0, 31));
      ifc.wd_a = $urandom;
      ifc.we_b = 1'($urandom_range(0, 1));
      ifc.wa_b = ($urandom_range(0, 3) == 0) ?
                 ifc.wa_a : 5'($urandom_range(0, 31));
      ifc.wd_b = $urandom;
      ifc.iss_v = ($urandom_range(0, 2) != 0);
      ifc.iss_addr = 5'($urandom_range(0, 31));
      ifc.ra1 = ($urandom_range(0, 2) == 0) ?
                ifc.wa_b : 5'($urandom_range(0, 31));
      ifc.ra2 = ($urandom_range(0, 2) == 0) ?
                ifc.iss_addr : 5'($urandom_range(0, 31));
      #1;
      model_chk("rnd");
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
